multi_edge_stretcher: RTL and testbench

- Multi-channel successor to the single-input posedge detector.
- Synchronises `N_CH` asynchronous inputs and detects a selectable edge type on each.
- Stretches each detected edge into an output pulse of a programmable length, with optional retrigger.
- Flags edges that were dropped during a hold. Sits between raw board inputs (buttons, external strobes) and the control logic that consumes clean, timed event pulses.

---
 rtl/multi_edge_stretcher.sv | 107 ++++++++++
 tb/tb_multi_edge_stretcher.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_stretcher.sv
// Multi-channel edge detector / pulse stretcher: synchronises N_CH async inputs,
// detects a selectable edge per channel and stretches it into a HOLD_CYCLES pulse.
module multi_edge_stretcher #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 125000000,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] inp,
    input  logic [1:0]      mode,
    input  logic            retrig,
    input  logic            clr,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] edge_pulse,
    output logic [N_CH-1:0] missed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   s_last;
        logic                   det;
        logic                   hold_q, hold_nxt;
        logic [CNT_W-1:0]       cnt_q, cnt_nxt;
        logic                   ep_q, ep_nxt;
        logic                   miss_q, miss_nxt;

        // Synchroniser and delayed copy; free-running, untouched by clr
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], inp[c]};
                prev_q <= s_last;
            end
        end

        assign s_last = sync_q[SYNC_STAGES-1];

        always_comb begin
            det = 1'b0;
            case (mode)
                2'b00:   det = s_last & ~prev_q;
                2'b01:   det = ~s_last & prev_q;
                2'b10:   det = s_last ^ prev_q;
                default: det = 1'b0;
            endcase
        end

        // Hold state register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= 1'b0;
                cnt_q  <= '0;
                ep_q   <= 1'b0;
                miss_q <= 1'b0;
            end else begin
                hold_q <= hold_nxt;
                cnt_q  <= cnt_nxt;
                ep_q   <= ep_nxt;
                miss_q <= miss_nxt;
            end
        end

        // Next hold state; a retriggered edge on the expiry cycle keeps out high
        always_comb begin
            hold_nxt = hold_q;
            cnt_nxt  = cnt_q;
            ep_nxt   = 1'b0;
            miss_nxt = miss_q;
            if (clr) begin
                hold_nxt = 1'b0;
                cnt_nxt  = '0;
                miss_nxt = 1'b0;
            end else if (!hold_q) begin
                cnt_nxt = '0;
                if (det) begin
                    hold_nxt = 1'b1;
                    ep_nxt   = 1'b1;
                end
            end else if (det && retrig) begin
                cnt_nxt = '0;
                ep_nxt  = 1'b1;
            end else begin
                if (det) begin
                    miss_nxt = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    hold_nxt = 1'b0;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
        end

        assign out[c]        = hold_q;
        assign edge_pulse[c] = ep_q;
        assign missed[c]     = miss_q;
    end

endmodule

// File: tb/tb_multi_edge_stretcher.sv
// Self-checking bench for multi_edge_stretcher: a per-cycle scoreboard fed by a
// remaining-cycles reference model, plus scenario-level counts against fixed values.
module tb_multi_edge_stretcher;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HOLD_CYCLES = 4;
    localparam int unsigned CNT_W       = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] inp;
    logic [1:0]      mode;
    logic            retrig;
    logic            clr;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] edge_pulse;
    logic [N_CH-1:0] missed;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] ep;
        logic [3:0] missed;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: last three sampled input levels and remaining high cycles
    logic [3:0] m_d1, m_d2, m_d3;
    logic [3:0] m_missed;
    int         m_rem[4];

    multi_edge_stretcher #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inp(inp), .mode(mode), .retrig(retrig), .clr(clr),
        .out(out), .edge_pulse(edge_pulse), .missed(missed)
    );

    always #5 clk = ~clk;

    task automatic reset_model();
        m_d1 = '0; m_d2 = '0; m_d3 = '0; m_missed = '0;
        for (int c = 0; c < 4; c++) m_rem[c] = 0;
        exp_q.delete();
    endtask

    // Predict the outputs after the coming clock edge, push them, then advance
    task automatic step();
        exp_t e;
        logic d;
        e = '0;
        for (int c = 0; c < 4; c++) begin
            d = 1'b0;
            if (mode == 2'b00) d = m_d2[c] & ~m_d3[c];
            if (mode == 2'b01) d = ~m_d2[c] & m_d3[c];
            if (mode == 2'b10) d = m_d2[c] ^ m_d3[c];
            if (clr) begin
                m_rem[c] = 0;
                m_missed[c] = 1'b0;
            end else if (d && (m_rem[c] == 0 || retrig)) begin
                m_rem[c] = int'(HOLD_CYCLES);
                e.ep[c] = 1'b1;
            end else begin
                if (d) m_missed[c] = 1'b1;
                if (m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
            end
            e.out[c]    = (m_rem[c] > 0);
            e.missed[c] = m_missed[c];
        end
        m_d3 = m_d2; m_d2 = m_d1; m_d1 = inp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; inp = '0; mode = 2'b00; retrig = 1'b0; clr = 1'b0;
        #12;
        n_cmp++;
        if ({out, edge_pulse, missed} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got out=%b ep=%b missed=%b, want all 0", out, edge_pulse, missed);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        for (int j = 0; j < 4; j++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL reset_idle step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
        end
    endtask

    // Rising edge latency and pulse width; mode 11 mid-hold must not cut the pulse
    task automatic test_latency();
        exp_t e;
        int first_out = -1;
        int n_out = 0;
        int n_ep = 0;
        mode = 2'b00; retrig = 1'b1; clr = 1'b0;
        for (int j = 0; j < 14; j++) begin
            if (j == 0) inp[0] = 1'b1;
            if (j == 3) mode = 2'b11;
            if (j == 10) begin mode = 2'b00; inp[0] = 1'b0; end
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL latency step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
            if (out[0]) begin
                if (first_out < 0) first_out = j;
                n_out++;
            end
            if (edge_pulse[0]) n_ep++;
        end
        n_cmp++;
        if (first_out != 2) begin n_fail++; $display("FAIL latency_first_out: got step %0d, want 2", first_out); end
        n_cmp++;
        if (n_out != 4) begin n_fail++; $display("FAIL latency_width: got %0d cycles, want 4", n_out); end
        n_cmp++;
        if (n_ep != 1) begin n_fail++; $display("FAIL latency_edge_pulses: got %0d, want 1", n_ep); end
    endtask

    task automatic test_falling_both();
        exp_t e;
        int n_ep1 = 0;
        int n_ep2 = 0;
        int n_out2 = 0;
        mode = 2'b01; retrig = 1'b1; clr = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (j == 0) inp[1] = 1'b1;
            if (j == 6) inp[1] = 1'b0;
            if (j == 14) begin mode = 2'b10; inp[2] = 1'b1; end
            if (j == 20) inp[2] = 1'b0;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL fall_both step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
            if (edge_pulse[1]) n_ep1++;
            if (edge_pulse[2]) n_ep2++;
            if (out[2]) n_out2++;
        end
        n_cmp++;
        if (n_ep1 != 1) begin n_fail++; $display("FAIL falling_pulses: got %0d, want 1", n_ep1); end
        n_cmp++;
        if (n_ep2 != 2) begin n_fail++; $display("FAIL both_pulses: got %0d, want 2", n_ep2); end
        n_cmp++;
        if (n_out2 != 8) begin n_fail++; $display("FAIL both_out_cycles: got %0d, want 8", n_out2); end
    endtask

    // Part A: second edge mid-hold; part B: second edge on the expiry cycle
    task automatic test_retrig();
        exp_t e;
        int n_out_a = 0;
        int n_out_b = 0;
        int n_rise = 0;
        int n_ep = 0;
        logic last = 1'b0;
        mode = 2'b00; retrig = 1'b1; clr = 1'b0;
        for (int j = 0; j < 26; j++) begin
            if (j == 0 || j == 2 || j == 12 || j == 16) inp[3] = 1'b1;
            if (j == 1 || j == 4 || j == 14 || j == 18) inp[3] = 1'b0;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL retrig step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
            if (out[3] && j < 12) n_out_a++;
            if (out[3] && j >= 12) n_out_b++;
            if (out[3] && !last) n_rise++;
            if (edge_pulse[3]) n_ep++;
            last = out[3];
        end
        n_cmp++;
        if (n_out_a != 6) begin n_fail++; $display("FAIL retrig_mid_width: got %0d, want 6", n_out_a); end
        n_cmp++;
        if (n_out_b != 8) begin n_fail++; $display("FAIL retrig_expiry_width: got %0d, want 8", n_out_b); end
        n_cmp++;
        if (n_rise != 2) begin n_fail++; $display("FAIL retrig_no_gap: got %0d out pulses, want 2", n_rise); end
        n_cmp++;
        if (n_ep != 4) begin n_fail++; $display("FAIL retrig_edge_pulses: got %0d, want 4", n_ep); end
    endtask

    task automatic test_no_retrig();
        exp_t e;
        int n_out = 0;
        int n_ep = 0;
        mode = 2'b00; retrig = 1'b0; clr = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 0 || j == 2) inp[0] = 1'b1;
            if (j == 1 || j == 3) inp[0] = 1'b0;
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL no_retrig step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
            if (out[0]) n_out++;
            if (edge_pulse[0]) n_ep++;
        end
        n_cmp++;
        if (n_out != 4) begin n_fail++; $display("FAIL no_retrig_width: got %0d, want 4", n_out); end
        n_cmp++;
        if (n_ep != 1) begin n_fail++; $display("FAIL no_retrig_edge_pulses: got %0d, want 1", n_ep); end
        n_cmp++;
        if (missed !== 4'b0001) begin n_fail++; $display("FAIL no_retrig_missed: got %b, want 0001", missed); end
    endtask

    // clr mid-hold at step 3, clr coincident with a detected edge at step 9
    task automatic test_clr();
        exp_t e;
        int n_ep = 0;
        int late_out = -1;
        mode = 2'b00; retrig = 1'b1; clr = 1'b0;
        for (int j = 0; j < 21; j++) begin
            if (j == 0 || j == 7 || j == 13) inp[1] = 1'b1;
            if (j == 5 || j == 11) inp[1] = 1'b0;
            clr = (j == 3 || j == 9);
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL clr step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
            if (j == 3) begin
                n_cmp++;
                if ({out, edge_pulse, missed} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL clr_mid_hold: got out=%b ep=%b missed=%b, want all 0", out, edge_pulse, missed);
                end
            end
            if (edge_pulse[1]) n_ep++;
            if (out[1] && j >= 4 && late_out < 0) late_out = j;
        end
        clr = 1'b0;
        n_cmp++;
        if (n_ep != 2) begin n_fail++; $display("FAIL clr_edge_pulses: got %0d, want 2", n_ep); end
        n_cmp++;
        if (late_out != 15) begin n_fail++; $display("FAIL clr_next_edge: got step %0d, want 15", late_out); end
    endtask

    task automatic test_reset_midhold();
        exp_t e;
        int n_ep;
        logic [1:0] m;
        mode = 2'b00; retrig = 1'b1; clr = 1'b0;
        inp[2] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                n_fail++;
                $display("FAIL pre_reset step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                         j, out, edge_pulse, missed, e.out, e.ep, e.missed);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out, edge_pulse, missed} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: got out=%b ep=%b missed=%b, want all 0", out, edge_pulse, missed);
        end
        for (int k = 0; k < 3; k++) begin
            m = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            mode = m;
            rst_n = 1'b1;
            reset_model();
            n_ep = 0;
            for (int j = 0; j < 8; j++) begin
                step();
                e = exp_q.pop_front();
                n_cmp++;
                if ({out, edge_pulse, missed} !== {e.out, e.ep, e.missed}) begin
                    n_fail++;
                    $display("FAIL release_mode%0d step %0d: got out=%b ep=%b missed=%b, want out=%b ep=%b missed=%b",
                             m, j, out, edge_pulse, missed, e.out, e.ep, e.missed);
                end
                if (edge_pulse[2]) n_ep++;
            end
            n_cmp++;
            if (n_ep != ((k == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL release_pulse_mode%0d: got %0d pulses, want %0d", m, n_ep, (k == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_falling_both();
        test_retrig();
        test_no_retrig();
        test_clr();
        test_reset_midhold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
